// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle. Results go back
// through the register file write port, with writes to x0 suppressed here.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_d,
  input  logic [31:0] rs2_d,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        ready,
  output logic        done,
  output logic        write_e,
  output logic [4:0]  rd_out,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [1:0]  r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [4:0]  r_rd;
  logic [31:0] r_result;

  // op[0]=0 selects the signed variants (DIV, REM); op[1]=1 selects remainder.
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_overflow;
  logic [32:0] w_shift;
  logic [33:0] w_trial;
  logic [31:0] w_rem_final;
  logic [31:0] w_quo_final;

  assign w_signed   = ~op[0];
  assign w_a_neg    = w_signed & rs1_d[31];
  assign w_b_neg    = w_signed & rs2_d[31];
  // Magnitude of 0x80000000 is itself, which is correct as an unsigned value.
  assign w_a_mag    = w_a_neg ? (32'd0 - rs1_d) : rs1_d;
  assign w_b_mag    = w_b_neg ? (32'd0 - rs2_d) : rs2_d;
  assign w_div_zero = (rs2_d == 32'd0);
  assign w_overflow = w_signed & (rs1_d == 32'h8000_0000) & (rs2_d == 32'hFFFF_FFFF);

  // Shift {rem, quo} left by one, then trial-subtract the divisor; bit 33 is the borrow.
  assign w_shift = {r_rem[31:0], r_quo[31]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_div};

  assign w_rem_final = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
  assign w_quo_final = r_neg_q ? (32'd0 - r_quo) : r_quo;

  // Control FSM and datapath registers; flush aborts and has priority over start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 6'd0;
      r_rem    <= 33'd0;
      r_quo    <= 32'd0;
      r_div    <= 32'd0;
      r_op     <= 2'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rd     <= 5'd0;
      r_result <= 32'd0;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= op;
            r_rd    <= rd_in;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div   <= w_b_mag;
            r_quo   <= w_a_mag;
            r_rem   <= 33'd0;
            r_cnt   <= 6'd0;
            if (w_div_zero) begin
              r_result <= op[1] ? rs1_d : 32'hFFFF_FFFF;
              r_state  <= DONE;
            end else if (w_overflow) begin
              r_result <= op[1] ? 32'd0 : 32'h8000_0000;
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (w_trial[33]) begin
            r_rem <= w_shift;
          end else begin
            r_rem <= w_trial[32:0];
          end
          r_quo <= {r_quo[30:0], ~w_trial[33]};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= FIX;
          end else begin
            r_state <= CALC;
          end
        end
        FIX: begin
          r_result <= r_op[1] ? w_rem_final : w_quo_final;
          r_state  <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign done    = (r_state == DONE);
  assign write_e = done & (r_rd != 5'd0);
  assign rd_out  = r_rd;
  assign result  = r_result;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider (DIV, DIVU, REM, REMU) in the execute stage. It takes its operands from the register file read ports (reg_d1 / reg_d2) and returns its result through the register file write port (rd / write_e / write_d). It runs a radix-2 restoring division, one quotient bit per cycle, with a ready/start request and a one-cycle done pulse. The register file does not protect x0, so this block gates writes to x0.

## Interface
- No parameters; data width is fixed at 32 (RV32M).

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only on a rising edge where ready=1 and flush=0
- op  in  2  instruction funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_d  in  32  dividend, driven from register file reg_d1
- rs2_d  in  32  divisor, driven from register file reg_d2
- rd_in  in  5  destination register index
- flush  in  1  abort any operation in flight
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; result and rd_out are valid
- write_e  out  1  done & (rd_out != 0); drives register file write_e
- rd_out  out  5  captured rd_in; drives register file rd
- result  out  32  quotient or remainder; drives register file write_d

## Operation
- States: IDLE, CALC, FIX, DONE.
- ready = (state==IDLE). done = (state==DONE).
- Acceptance edge:
  - Capture op and rd_in.
  - For signed ops (DIV, REM), capture the operand magnitudes |rs1_d| and |rs2_d|, plus neg_q = sign(rs1_d) ^ sign(rs2_d) and neg_r = sign(rs1_d).
  - For unsigned ops, capture the raw values; neg_q = neg_r = 0.
- Special cases on acceptance go IDLE->DONE and load result directly:
  - Divisor == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1_d.
  - DIV with rs1_d=0x80000000 and rs2_d=0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0.
- Normal case, IDLE->CALC:
  - Clear the 6-bit counter and the 33-bit partial remainder. The quotient register holds the dividend magnitude.
  - Each CALC edge: shift {rem, quo} left by 1, then trial-subtract the divisor. If the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0. Increment the counter.
  - The edge that completes iteration 32 (counter == 31) moves the FSM to FIX.
- FIX->DONE: result = quotient (negated if neg_q) for DIV/DIVU, or remainder (negated if neg_r) for REM/REMU. Negation is two's complement, mod 2^32.
- DONE->IDLE on the next edge, unconditionally.
- start while ready=0 is ignored; no queueing.
- flush=1 on any edge: state->IDLE, no done pulse. flush has priority over start.
- Operands and rd_in may change after acceptance without affecting the operation.

## Timing
- Reset values:
  - state IDLE, so ready=1 during and after reset.
  - done=0, write_e=0, rd_out=0, result=0.
  - Counter and internal registers 0.
- Reset asserted mid-operation aborts immediately (asynchronous). No done is produced.
- result and rd_out are registered. They hold their value after done until the next result load.
- Latency, with start sampled in cycle 0:
  - Normal: done in cycle 34. Earliest next acceptance is cycle 35.
  - Special case: done in cycle 1. Earliest next acceptance is cycle 2.
- done and write_e are high for exactly one cycle per completed operation.

## Test plan
- DIVU rs1=100, rs2=7, rd=5 -> done in cycle 34 only; result=14, rd_out=5, write_e=1. REMU with the same operands -> result=2.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF. REM 7 / 0xFFFFFFFE -> 1. DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF.
- Divide by zero, rs1=5, rs2=0: DIVU and DIV -> 0xFFFFFFFF; REMU and REM -> 5. Each with done in cycle 1.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done in cycle 1. REM with the same operands -> 0.
- DIVU 9 / 3 with rd_in=0 -> done pulses with result=3, write_e stays 0.
- Flush in cycle 10 -> ready=1 from cycle 11, no done pulse. start held high in cycles 1-20 -> ignored while busy. rst asserted mid-CALC -> all outputs at reset values immediately, no done. A new DIVU 8/2 after that -> result 4.
